// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID-stage control for a 5-stage MIPS-like pipeline.
//   Decodes the ID instruction into a registered ID/EX control bundle. It also
//   detects load-use and jr/jalr-source hazards and drives the PC-select and
//   IF/ID flush controls combinationally.
// Optional feature: define PIPE_CTRL_MULDIV_EN to add a multi-cycle multiply
//   sequencer (IDLE/BUSY FSM plus down-counter). When it is undefined, funct
//   0x18 decodes as an ordinary R-type instruction.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   op_id, funct_id          ID instruction [31:26] and [5:0]
//   rs_id, rt_id, rd_id      ID register fields
//   eq_id                    ID branch comparator result
//   ex_regwrite .. ex_dst    registered ID/EX control bundle
//   pc_sel                   00 PC+4, 01 branch, 10 jump, 11 rs (combinational)
//   if_flush                 clear IF/ID (combinational)
//   stall                    hold PC and IF/ID (combinational)
module pipe_ctrl_unit #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op_id,
   input  logic [5:0]        funct_id,
   input  logic [REG_AW-1:0] rs_id,
   input  logic [REG_AW-1:0] rt_id,
   input  logic [REG_AW-1:0] rd_id,
   input  logic              eq_id,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_memtoreg,
   output logic              ex_alusrc,
   output logic [1:0]        ex_aluop,
   output logic [REG_AW-1:0] ex_dst,
   output logic [1:0]        pc_sel,
   output logic              if_flush,
   output logic              stall
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] F_JR     = 6'h08;
   localparam logic [5:0] F_JALR   = 6'h09;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;
   localparam logic [1:0] ALU_IMM  = 2'b11;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   localparam logic [1:0] PC_RS  = 2'b11;

   // Reject multiply latencies the 4-bit counter cannot hold
   if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
      $error("pipe_ctrl_unit: MUL_LAT must be in 2..15");
   end

   typedef struct packed {
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
      logic              alusrc;
      logic [1:0]        aluop;
      logic [REG_AW-1:0] dst;
   } ctrl_t;

   ctrl_t dec;
   ctrl_t ex_q;

   logic is_rtype;
   logic is_jr;
   logic is_jalr;
   logic is_beq;
   logic is_sw;
   logic is_jmp;
   logic uses_rt;
   logic lu_hazard;
   logic jr_hazard;
   logic hz_stall;

   // Instruction class flags used by hazard and redirect logic
   assign is_rtype = (op_id == OP_RTYPE);
   assign is_jr    = is_rtype && (funct_id == F_JR);
   assign is_jalr  = is_rtype && (funct_id == F_JALR);
   assign is_beq   = (op_id == OP_BEQ);
   assign is_sw    = (op_id == OP_SW);
   assign is_jmp   = (op_id == OP_J) || (op_id == OP_JAL);
   assign uses_rt  = is_rtype || is_beq || is_sw;

`ifdef PIPE_CTRL_MULDIV_EN
   localparam int unsigned CNT_W  = 4;
   localparam logic [5:0]  F_MULT = 6'h18;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } mul_state_t;

   mul_state_t       mul_state;
   logic [CNT_W-1:0] mul_cnt;
   logic             is_mult;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;

   assign is_mult   = is_rtype && (funct_id == F_MULT);
   assign mul_start = (mul_state == S_IDLE) && is_mult && !hz_stall;
   assign mul_busy  = (mul_state == S_BUSY);
   // Last busy cycle: counter is about to reach zero
   assign mul_done  = mul_busy && (mul_cnt == CNT_W'(1));
`endif

   // Combinational decode of the ID instruction; unknown opcodes stay a bubble
   always_comb begin
      dec = '0;
      case (op_id)
         OP_RTYPE: begin
            dec.aluop = ALU_FUNC;
            case (funct_id)
               F_JR: ;
`ifdef PIPE_CTRL_MULDIV_EN
               // mult writes HI/LO, not the register file
               F_MULT: ;
`endif
               default: begin
                  dec.regwrite = 1'b1;
                  dec.dst      = rd_id;
               end
            endcase
         end
         OP_BEQ:  dec.aluop = ALU_SUB;
         OP_J:    ;
         OP_JAL: begin
            dec.regwrite = 1'b1;
            dec.dst      = REG_AW'(31);
         end
         OP_LW: begin
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.dst      = rt_id;
         end
         OP_SW: begin
            dec.memwrite = 1'b1;
            dec.alusrc   = 1'b1;
         end
         OP_ADDI: begin
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.aluop    = ALU_ADD;
            dec.dst      = rt_id;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.aluop    = ALU_IMM;
            dec.dst      = rt_id;
         end
         default: dec = '0;
      endcase
   end

   // Register 0 is never a real producer, so it never creates a hazard
   assign lu_hazard = ex_q.memread && (ex_q.dst != '0) &&
                      ((ex_q.dst == rs_id) || (uses_rt && (ex_q.dst == rt_id)));
   assign jr_hazard = (is_jr || is_jalr) && ex_q.regwrite && (ex_q.dst != '0) &&
                      (ex_q.dst == rs_id);
   assign hz_stall  = lu_hazard || jr_hazard;

`ifdef PIPE_CTRL_MULDIV_EN
   assign stall = !rst && (hz_stall || mul_busy);
`else
   assign stall = !rst && hz_stall;
`endif

   // Redirect only when the ID instruction actually advances
   always_comb begin
      pc_sel   = PC_SEQ;
      if_flush = 1'b0;
      if (!rst && !stall) begin
         if (is_beq && eq_id) begin
            pc_sel   = PC_BR;
            if_flush = 1'b1;
         end else if (is_jmp) begin
            pc_sel   = PC_JMP;
            if_flush = 1'b1;
         end else if (is_jr || is_jalr) begin
            pc_sel   = PC_RS;
            if_flush = 1'b1;
         end
      end
   end

   // ID/EX control register; stalls and multiply start insert bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
`ifdef PIPE_CTRL_MULDIV_EN
      end else if (mul_done) begin
         ex_q       <= '0;
         ex_q.aluop <= ALU_FUNC;
      end else if (stall || mul_start) begin
         ex_q <= '0;
`else
      end else if (stall) begin
         ex_q <= '0;
`endif
      end else begin
         ex_q <= dec;
      end
   end

`ifdef PIPE_CTRL_MULDIV_EN
   // Multiply sequencer: IDLE -> BUSY for MUL_LAT-1 cycles -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_state <= S_IDLE;
         mul_cnt   <= '0;
      end else begin
         case (mul_state)
            S_IDLE: begin
               if (mul_start) begin
                  mul_state <= S_BUSY;
                  mul_cnt   <= CNT_W'(MUL_LAT - 1);
               end
            end
            S_BUSY: begin
               mul_cnt <= mul_cnt - CNT_W'(1);
               if (mul_cnt == CNT_W'(1)) begin
                  mul_state <= S_IDLE;
               end
            end
            default: begin
               mul_state <= S_IDLE;
               mul_cnt   <= '0;
            end
         endcase
      end
   end
`endif

   assign ex_regwrite = ex_q.regwrite;
   assign ex_memread  = ex_q.memread;
   assign ex_memwrite = ex_q.memwrite;
   assign ex_memtoreg = ex_q.memtoreg;
   assign ex_alusrc   = ex_q.alusrc;
   assign ex_aluop    = ex_q.aluop;
   assign ex_dst      = ex_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode, hazards, redirects, reset and
// (when PIPE_CTRL_MULDIV_EN is defined) the multiply sequencer.
module tb_pipe_ctrl_unit;

   localparam int unsigned REG_AW = 5;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BAD  = 6'h3F;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_JALR  = 6'h09;
   localparam logic [5:0] F_MULT  = 6'h18;

   logic              clk = 1'b0;
   logic              rst;
   logic [5:0]        op_id;
   logic [5:0]        funct_id;
   logic [REG_AW-1:0] rs_id;
   logic [REG_AW-1:0] rt_id;
   logic [REG_AW-1:0] rd_id;
   logic              eq_id;
   logic              ex_regwrite;
   logic              ex_memread;
   logic              ex_memwrite;
   logic              ex_memtoreg;
   logic              ex_alusrc;
   logic [1:0]        ex_aluop;
   logic [REG_AW-1:0] ex_dst;
   logic [1:0]        pc_sel;
   logic              if_flush;
   logic              stall;
   logic [11:0]       ex_bus;

   int errors = 0;
   int checks = 0;

   pipe_ctrl_unit #(.REG_AW(REG_AW), .MUL_LAT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .op_id       (op_id),
      .funct_id    (funct_id),
      .rs_id       (rs_id),
      .rt_id       (rt_id),
      .rd_id       (rd_id),
      .eq_id       (eq_id),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_memwrite (ex_memwrite),
      .ex_memtoreg (ex_memtoreg),
      .ex_alusrc   (ex_alusrc),
      .ex_aluop    (ex_aluop),
      .ex_dst      (ex_dst),
      .pc_sel      (pc_sel),
      .if_flush    (if_flush),
      .stall       (stall)
   );

   always #5 clk = ~clk;

   assign ex_bus = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                    ex_alusrc, ex_aluop, ex_dst};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_ctl(input string tag, input logic s,
                            input logic [1:0] ps, input logic fl);
      check({tag, "_stall"},  32'(stall),    32'(s));
      check({tag, "_pc_sel"}, 32'(pc_sel),   32'(ps));
      check({tag, "_flush"},  32'(if_flush), 32'(fl));
   endtask

   function automatic logic [11:0] bnd(input logic rw, input logic mr,
                                       input logic mw, input logic mt,
                                       input logic as, input logic [1:0] op,
                                       input logic [4:0] d);
      return {rw, mr, mw, mt, as, op, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] f,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic eq);
      op_id    = op;
      funct_id = f;
      rs_id    = rs;
      rt_id    = rt;
      rd_id    = rd;
      eq_id    = eq;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(OP_JAL, 6'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      check_ctl("rst_jal", 1'b0, 2'b00, 1'b0);
      step();
      check("rst_ex", 32'(ex_bus), 32'(0));
      step();
      rst = 1'b0;
      drive(OP_BAD, 6'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      step();

      // lw r5 ; add r1,r5,r2 -> one load-use stall
      drive(OP_LW, 6'h0, 5'd0, 5'd5, 5'd0, 1'b0);
      check_ctl("lw", 1'b0, 2'b00, 1'b0);
      step();
      check("lw_ex", 32'(ex_bus), 32'(bnd(1, 1, 0, 1, 1, 2'b00, 5'd5)));
      drive(OP_R, F_ADD, 5'd5, 5'd2, 5'd1, 1'b0);
      check_ctl("lu_add", 1'b1, 2'b00, 1'b0);
      step();
      check("lu_bubble", 32'(ex_bus), 32'(0));
      check_ctl("lu_release", 1'b0, 2'b00, 1'b0);
      step();
      check("add_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 0, 2'b10, 5'd1)));

      // beq taken then not taken in the same cycle
      drive(OP_BEQ, 6'h0, 5'd3, 5'd6, 5'd0, 1'b1);
      check_ctl("beq_taken", 1'b0, 2'b01, 1'b1);
      eq_id = 1'b0;
      #1;
      check_ctl("beq_nt", 1'b0, 2'b00, 1'b0);
      step();
      check("beq_ex", 32'(ex_bus), 32'(bnd(0, 0, 0, 0, 0, 2'b01, 5'd0)));

      // jal
      drive(OP_JAL, 6'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      check_ctl("jal", 1'b0, 2'b10, 1'b1);
      step();
      check("jal_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 0, 2'b00, 5'd31)));

      // addi r4 ; jr r4 -> one stall then redirect to rs
      drive(OP_ADDI, 6'h0, 5'd0, 5'd4, 5'd0, 1'b0);
      check_ctl("addi", 1'b0, 2'b00, 1'b0);
      step();
      check("addi_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 1, 2'b00, 5'd4)));
      drive(OP_R, F_JR, 5'd4, 5'd0, 5'd0, 1'b0);
      check_ctl("jr_hz", 1'b1, 2'b00, 1'b0);
      step();
      check("jr_bubble", 32'(ex_bus), 32'(0));
      check_ctl("jr_go", 1'b0, 2'b11, 1'b1);
      step();
      check("jr_ex", 32'(ex_bus), 32'(bnd(0, 0, 0, 0, 0, 2'b10, 5'd0)));

      // lw r0 ; add r1,r0,r0 -> no stall
      drive(OP_LW, 6'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      step();
      check("lw0_ex", 32'(ex_bus), 32'(bnd(1, 1, 0, 1, 1, 2'b00, 5'd0)));
      drive(OP_R, F_ADD, 5'd0, 5'd0, 5'd1, 1'b0);
      check_ctl("r0_nohz", 1'b0, 2'b00, 1'b0);
      step();
      check("add_r0_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 0, 2'b10, 5'd1)));

      // rt of addi is a destination: no load-use stall
      drive(OP_LW, 6'h0, 5'd0, 5'd7, 5'd0, 1'b0);
      step();
      drive(OP_ADDI, 6'h0, 5'd0, 5'd7, 5'd0, 1'b0);
      check_ctl("addi_rt_nohz", 1'b0, 2'b00, 1'b0);
      step();
      check("addi7_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 1, 2'b00, 5'd7)));

      // rt of sw is a source: load-use stall
      drive(OP_LW, 6'h0, 5'd0, 5'd7, 5'd0, 1'b0);
      step();
      drive(OP_SW, 6'h0, 5'd0, 5'd7, 5'd0, 1'b0);
      check_ctl("sw_rt_hz", 1'b1, 2'b00, 1'b0);
      step();
      check("sw_bubble", 32'(ex_bus), 32'(0));
      step();
      check("sw_ex", 32'(ex_bus), 32'(bnd(0, 0, 1, 0, 1, 2'b00, 5'd0)));

      // lw r9 ; jr r9 -> load-use and jr hazards together, single stall
      drive(OP_LW, 6'h0, 5'd0, 5'd9, 5'd0, 1'b0);
      step();
      drive(OP_R, F_JR, 5'd9, 5'd0, 5'd0, 1'b0);
      check_ctl("dual_hz", 1'b1, 2'b00, 1'b0);
      step();
      check("dual_bubble", 32'(ex_bus), 32'(0));
      check_ctl("dual_go", 1'b0, 2'b11, 1'b1);
      step();

      // Unknown opcode is a bubble; andi; j; jalr
      drive(OP_BAD, 6'h0, 5'd1, 5'd2, 5'd3, 1'b0);
      step();
      check("bad_op_ex", 32'(ex_bus), 32'(0));
      drive(OP_ANDI, 6'h0, 5'd0, 5'd6, 5'd0, 1'b0);
      step();
      check("andi_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 1, 2'b11, 5'd6)));
      drive(OP_J, 6'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      check_ctl("j", 1'b0, 2'b10, 1'b1);
      step();
      check("j_ex", 32'(ex_bus), 32'(0));
      drive(OP_R, F_JALR, 5'd2, 5'd0, 5'd7, 1'b0);
      check_ctl("jalr", 1'b0, 2'b11, 1'b1);
      step();
      check("jalr_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 0, 2'b10, 5'd7)));

`ifndef PIPE_CTRL_MULDIV_EN
      // Without multiply support funct 0x18 is a plain R-type
      drive(OP_R, F_MULT, 5'd1, 5'd2, 5'd3, 1'b0);
      check_ctl("mult_plain", 1'b0, 2'b00, 1'b0);
      step();
      check("mult_plain_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 0, 2'b10, 5'd3)));
`else
      // mult: 3 stall cycles, 3 bubbles, then the mult bundle
      drive(OP_R, F_MULT, 5'd1, 5'd2, 5'd0, 1'b0);
      check_ctl("mult_issue", 1'b0, 2'b00, 1'b0);
      step();
      check("mult_bubble0", 32'(ex_bus), 32'(0));
      drive(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check_ctl("mult_busy", 1'b1, 2'b00, 1'b0);
         step();
         if (i < 2) check("mult_bubble", 32'(ex_bus), 32'(0));
         else check("mult_ex", 32'(ex_bus), 32'(bnd(0, 0, 0, 0, 0, 2'b10, 5'd0)));
      end
      check_ctl("mult_end", 1'b0, 2'b00, 1'b0);
      step();
      check("after_mult_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 0, 2'b10, 5'd3)));

      // Reset during the second busy cycle aborts the multiply
      drive(OP_R, F_MULT, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      drive(OP_BAD, 6'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      check_ctl("mrst_busy1", 1'b1, 2'b00, 1'b0);
      step();
      rst = 1'b1;
      #1;
      check_ctl("mrst_during", 1'b0, 2'b00, 1'b0);
      step();
      rst = 1'b0;
      #1;
      check_ctl("mrst_after", 1'b0, 2'b00, 1'b0);
      check("mrst_ex", 32'(ex_bus), 32'(0));
      step();
      check_ctl("mrst_idle", 1'b0, 2'b00, 1'b0);
`endif

      // Reset clears a non-zero ID/EX bundle
      drive(OP_ADDI, 6'h0, 5'd0, 5'd4, 5'd0, 1'b0);
      step();
      check("pre_rst_ex", 32'(ex_bus), 32'(bnd(1, 0, 0, 0, 1, 2'b00, 5'd4)));
      rst = 1'b1;
      step();
      check("final_rst_ex", 32'(ex_bus), 32'(0));
      check_ctl("final_rst", 1'b0, 2'b00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL provide parameter REG_AW, default 5, register-address width.
REQ-002 SHALL provide parameter MUL_LAT, default 4, multiply busy cycles (legal range 2..15).
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports, clock and reset first:
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 op_id  in  6  ID-stage instruction[31:26].
REQ-007 funct_id  in  6  ID-stage instruction[5:0].
REQ-008 rs_id / rt_id / rd_id  in  REG_AW each  ID-stage source and destination fields.
REQ-009 eq_id  in  1  ID-stage branch comparator result.
REQ-010 ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc  out  1 each  registered ID/EX controls.
REQ-011 ex_aluop  out  2  registered ALU op class: 00 add, 01 sub, 10 funct-decoded, 11 immediate-logic.
REQ-012 ex_dst  out  REG_AW  registered destination register (rd, rt, or 31 for jal).
REQ-013 pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs register.
REQ-014 if_flush  out  1  clear IF/ID register.
REQ-015 stall  out  1  hold PC and IF/ID.

Function
REQ-016 Decode SHALL be: R-type (op 0x00) regwrite, dst=rd, aluop 10; jr (funct 0x08) no write, pc_sel 11; jalr (funct 0x09) write, dst=rd, pc_sel 11; beq (0x04) aluop 01; j (0x02) pc_sel 10; jal (0x03) write, dst=31, pc_sel 10; lw (0x23) memread, memtoreg, alusrc, write, dst=rt; sw (0x2B) memwrite, alusrc; addi (0x08) alusrc, write, aluop 00; andi/ori/xori/slti (0x0C/0x0D/0x0E/0x0A) alusrc, write, aluop 11; any other opcode is a bubble.
REQ-017 The ID/EX control bundle SHALL register decode each cycle, with 1-cycle latency.
REQ-018 Load-use hazard SHALL assert stall combinationally when ex_memread=1, ex_dst!=0, and ex_dst equals rs_id, or equals rt_id for R-type/beq/sw.
REQ-019 jr/jalr hazard SHALL assert stall when ex_regwrite=1, ex_dst!=0, and ex_dst==rs_id.
REQ-020 While stall=1, the next ID/EX bundle SHALL be all-zero (bubble).
REQ-021 While stall=1, pc_sel SHALL be 00 and if_flush SHALL be 0.
REQ-022 Otherwise beq with eq_id=1, j, jal, jr and jalr SHALL set if_flush=1 and the pc_sel given in REQ-016.
REQ-023 beq with eq_id=0 SHALL give pc_sel 00 and if_flush 0.
REQ-024 A writeback to register 0 SHALL never raise a hazard.
REQ-025 Simultaneous load-use and jr hazards SHALL produce a single stall; priority is stall > redirect.

Reset
REQ-026 On rst=1 at a clock edge, all ex_* outputs SHALL become 0.
REQ-027 On the same reset, the multiply FSM SHALL return to IDLE with counter 0.
REQ-028 While rst=1, stall, pc_sel and if_flush SHALL be 0.
REQ-029 Reset SHALL abort an in-flight multiply without a further stall cycle.

Configuration
REQ-030 Macro PIPE_CTRL_MULDIV_EN SHALL control multiply support.
REQ-031 With PIPE_CTRL_MULDIV_EN defined, an FSM with states IDLE and BUSY SHALL be present.
REQ-032 In IDLE, an R-type instruction with funct 0x18 (mult) and no other stall SHALL move the FSM to BUSY and load the counter with MUL_LAT-1.
REQ-033 In BUSY, stall SHALL be 1 and ID/EX SHALL receive bubbles.
REQ-034 In BUSY, the counter SHALL decrement each cycle and, on reaching 0, the FSM SHALL return to IDLE and issue the mult bundle (regwrite 0, aluop 10).
REQ-035 Total stall for a mult SHALL be exactly MUL_LAT-1 cycles.
REQ-036 With PIPE_CTRL_MULDIV_EN undefined, funct 0x18 SHALL decode as a plain R-type and no FSM or counter logic SHALL exist.

Verification
REQ-037 lw r5 then add r1,r5,r2 -> stall=1 for 1 cycle; next ex_* bundle all zero; then add issues with ex_dst=1.
REQ-038 beq with eq_id=1, no hazard -> pc_sel=01, if_flush=1 in the same cycle; with eq_id=0 -> pc_sel=00, if_flush=0.
REQ-039 jal -> pc_sel=10, if_flush=1; next cycle ex_regwrite=1, ex_dst=31.
REQ-040 addi r4 then jr r4 -> 1 stall cycle with pc_sel=00; following cycle pc_sel=11, if_flush=1.
REQ-041 MULDIV_EN, MUL_LAT=4, mult issued -> stall=1 for 3 cycles, then bubble count 3; rst asserted in 2nd busy cycle -> stall=0 next cycle, all ex_*=0.
REQ-042 lw r0 followed by add r1,r0,r0 -> no stall.
